// File: rtl/seg7_bcd_reader.sv
// seg7_bcd_reader: watches a multiplexed 7-segment bus (segment + digit-select
// lines) and rebuilds one coherent BCD frame per complete display scan.
module seg7_bcd_reader #(
    parameter int NB_DIGITS     = 4,
    parameter bit SEG_POLARITY  = 1'b0,
    parameter bit SEL_POLARITY  = 1'b0,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [6:0]             Seg,
    input  logic [NB_DIGITS-1:0]   Sel,
    output logic [4*NB_DIGITS-1:0] Digits,
    output logic                   Valid,
    output logic                   SegErr,
    output logic                   FrameStrobe
);

    localparam int SW = 7 + NB_DIGITS;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {WAIT_STABLE, CAPTURE, HOLD} state_t;

    logic [6:0]             seg_s1_q, seg_s2_q;
    logic [NB_DIGITS-1:0]   sel_s1_q, sel_s2_q;
    logic [SW-1:0]          cur_smp;
    logic [SW-1:0]          smp_q;
    logic [7:0]             cnt_q, cnt_d;
    logic                   changed, cur_onehot;
    state_t                 state_q, state_d;
    logic                   capture_en;
    logic [NB_DIGITS-1:0]   cap_sel;
    logic [6:0]             cap_seg;
    logic [3:0]             nibble;
    logic                   bad_pat;
    logic                   frame_done;
    logic [NB_DIGITS-1:0]   mask_q, mask_d;
    logic                   segerr_q, segerr_d;
    logic [4*NB_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NB_DIGITS-1:0] digits_q;
    logic                   valid_q, strobe_q;

    // Two-flop synchronizers for the asynchronous display bus
    always_ff @(posedge Clk) begin
        if (Rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            sel_s1_q <= '0;
            sel_s2_q <= '0;
        end else begin
            seg_s1_q <= Seg;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= Sel;
            sel_s2_q <= sel_s1_q;
        end
    end

    // Normalize to active-high and compare against the previous sample
    always_comb begin
        cur_smp[SW-1:NB_DIGITS] = SEG_POLARITY ? seg_s2_q : ~seg_s2_q;
        cur_smp[NB_DIGITS-1:0]  = SEL_POLARITY ? sel_s2_q : ~sel_s2_q;
        changed    = (cur_smp != smp_q);
        cur_onehot = (cur_smp[NB_DIGITS-1:0] != '0) &&
                     ((cur_smp[NB_DIGITS-1:0] & (cur_smp[NB_DIGITS-1:0] - 1'b1)) == '0);
        if (changed)
            cnt_d = 8'd1;
        else if (cnt_q < STABLE)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;
    end

    // Previous-sample register and saturating stability counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            smp_q <= '0;
            cnt_q <= '0;
        end else begin
            smp_q <= cur_smp;
            cnt_q <= cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= WAIT_STABLE;
        else     state_q <= state_d;
    end

    // FSM next state: enter CAPTURE on the cycle the count reaches its target
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_STABLE: if (cnt_d == STABLE && cur_onehot) state_d = CAPTURE;
            CAPTURE:     state_d = changed ? WAIT_STABLE : HOLD;
            HOLD:        if (changed) state_d = WAIT_STABLE;
            default:     state_d = WAIT_STABLE;
        endcase
    end

    // FSM outputs: decode the stable sample held in smp_q while capturing
    always_comb begin
        capture_en = (state_q == CAPTURE);
        cap_sel    = smp_q[NB_DIGITS-1:0];
        cap_seg    = smp_q[SW-1:NB_DIGITS];
        bad_pat    = 1'b0;
        case (cap_seg)
            7'b1111110: nibble = 4'd0;
            7'b0110000: nibble = 4'd1;
            7'b1101101: nibble = 4'd2;
            7'b1111001: nibble = 4'd3;
            7'b0110011: nibble = 4'd4;
            7'b1011011: nibble = 4'd5;
            7'b1011111: nibble = 4'd6;
            7'b1110000: nibble = 4'd7;
            7'b1111111: nibble = 4'd8;
            7'b1111011: nibble = 4'd9;
            default: begin
                nibble  = 4'hF;
                bad_pat = 1'b1;
            end
        endcase
    end

    // Frame assembly: completion clears mask/error; a capture in the same
    // cycle still lands, so no digit is ever lost across the boundary
    always_comb begin
        frame_done = &mask_q;
        mask_d     = (frame_done ? '0 : mask_q) | (capture_en ? cap_sel : '0);
        segerr_d   = (frame_done ? 1'b0 : segerr_q) | (capture_en & bad_pat);
        shadow_d   = shadow_q;
        for (int unsigned i = 0; i < NB_DIGITS; i++) begin
            if (capture_en && cap_sel[i])
                shadow_d[i*4 +: 4] = nibble;
        end
    end

    // Shadow/mask/error registers and published frame
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mask_q   <= '0;
            segerr_q <= 1'b0;
            shadow_q <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            segerr_q <= segerr_d;
            shadow_q <= shadow_d;
            strobe_q <= frame_done;
            if (frame_done) begin
                digits_q <= shadow_q;
                valid_q  <= ~segerr_q;
            end
        end
    end

    assign Digits      = digits_q;
    assign Valid       = valid_q;
    assign SegErr      = segerr_q;
    assign FrameStrobe = strobe_q;

endmodule

// File: doc/seg7_bcd_reader.md
Name: seg7_bcd_reader

Overview:
- Monitors a multiplexed 7-segment display bus (segment lines plus digit-select lines) and reconstructs the BCD value of every digit.
- It is the reading end of the BCD-to-7-segment display path in the frequency meter. Uses:
  - loop-back self-test of the display driver;
  - capturing the readout of an external meter.
- Outputs one coherent frame of BCD digits per complete scan, plus error and valid flags.

Parameters:
- NB_DIGITS, 4: number of multiplexed digits; also the width of Sel.
- SEG_POLARITY, 0: 0 = segment lit when line is '0'; 1 = lit when '1'.
- SEL_POLARITY, 0: 0 = digit selected when its Sel line is '0'; 1 = when '1'.
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is captured (range 2..255).

Ports:
- Clk, input, 1: system clock.
- Rst, input, 1: synchronous reset, active high.
- Seg, input, 7: segment lines; bit6 = a ... bit0 = g.
- Sel, input, NB_DIGITS: digit-select lines; bit i = digit i, digit 0 = least significant.
- Digits, output, 4*NB_DIGITS: BCD frame; nibble i = digit i.
- Valid, output, 1: last published frame contained no undecodable pattern.
- SegErr, output, 1: sticky; an undecodable pattern was seen in the frame currently being assembled.
- FrameStrobe, output, 1: one-cycle pulse when Digits and Valid are updated.

Behaviour:
- Reset (Rst=1 at a Clk edge): Digits=0, Valid=0, SegErr=0, FrameStrobe=0. Synchronizers, stability counter, capture mask and shadow digits are all cleared. A reset mid-frame discards the partial frame.
- Input path:
  - Seg and Sel each pass through a 2-flop synchronizer.
  - They are then normalized to active-high according to SEG_POLARITY and SEL_POLARITY.
- Stability counter:
  - Compares the current normalized sample {Seg,Sel} with the previous one.
  - Mismatch: counter reset to 1.
  - Match: counter increments, saturating at STABLE_CYCLES.
- State machine:
  - WAIT_STABLE: counter < STABLE_CYCLES, or Sel is not one-hot (all-zero or multi-hot). No capture.
  - CAPTURE (single cycle): counter reaches STABLE_CYCLES and Sel is one-hot.
    - Decode Seg, write the nibble to shadow slot i, set mask bit i.
    - Go to HOLD.
  - HOLD: no further capture during this dwell. Any change of the sample returns to WAIT_STABLE.
- Decode table (normalized Seg):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - Any other pattern (including blank) → nibble 4'hF and SegErr set.
- Frame completion:
  - Triggered when the capture mask becomes all ones.
  - On the following cycle: Digits ← shadow, Valid ← ~SegErr (including an error from the final capture), FrameStrobe=1.
  - In the same cycle the mask and SegErr are cleared.
- Recapture: a digit captured twice before its frame completes is overwritten by the later value (e.g. select returns to the same digit after a glitch).
- Order independence: the completing capture is whichever digit fills the mask. Scan direction and order do not matter.
- Latency: Sel/Seg edge → capture = 2 (sync) + STABLE_CYCLES cycles. Capture of last digit → FrameStrobe = 1 cycle.
- Between frames: Digits and Valid hold their values until the next FrameStrobe.

Test Plan:
1. Nominal scan, SEG_POLARITY=0, SEL_POLARITY=0.
   - Stimulus: Sel=1110 with Seg=1001111 ('1'), then 1101 with Seg=0010010 ('2'), then 1011 with Seg=0000110 ('3'), then 0111 with Seg=1001100 ('4'); 8 cycles per digit.
   - Required: one FrameStrobe; Digits=16'h4321; Valid=1; SegErr=0 after strobe.
2. Short dwell.
   - Stimulus: one digit held for only 3 synchronized cycles with STABLE_CYCLES=4.
   - Required: no capture and no FrameStrobe. After a proper 8-cycle dwell, the frame completes.
3. Bad pattern.
   - Stimulus: digit 2 driven with blank (normalized 0000000).
   - Required: SegErr=1 until strobe; Digits=16'h4F21; Valid=0; next clean scan gives Valid=1.
4. Illegal select.
   - Stimulus: Sel=1100 (multi-hot) or 1111 (none) for 20 cycles.
   - Required: no mask change and no capture.
5. Reset mid-frame.
   - Stimulus: Rst after 2 digits captured.
   - Required: all outputs 0. A fresh full scan is needed; the old partial digits never appear.
6. Reverse order / recapture.
   - Stimulus: scan digits 3,2,1,0, with digit 1 shown twice ('5' then '7').
   - Required: strobe after digit 0; nibble 1 = 7.
